enemy_scheduler: RTL and testbench
==================================

Name: enemy_scheduler

Overview:
- Central controller for a bank of N enemy slots.
- Decides when and where each enemy spawns: timed spawn requests, a round-robin free-slot search, and LFSR-derived x positions.
- Broadcasts a periodic move-down pulse to all slots and tallies kills into a score.
- Declares game over when any live enemy descends past the lose line; sits between the game top level and the enemy instances.

Parameters:
- N_ENEMIES, 8, number of enemy slots (2..16).
- SPAWN_TICKS, 50_000_000, clk cycles between spawn requests.
- MOVE_TICKS, 25_000_000, clk cycles between move pulses.
- LOSE_Y, 9'd440, enemy centre y at or beyond which the game is lost.
- X_MIN, 10'd32, minimum legal spawn centre x (inclusive).
- X_MAX, 10'd607, maximum legal spawn centre x (inclusive).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- start  in  1  begin game (level or pulse, sampled in S_IDLE)
- alive  in  N_ENEMIES  per-slot alive flag
- killed  in  N_ENEMIES  per-slot single-cycle kill flag
- enemy_y  in  9*N_ENEMIES  per-slot centre y, slot i at bits [9i+8:9i]
- spawn  out  N_ENEMIES  one-hot single-cycle spawn command
- write_x_d  out  10  spawn x; valid whenever spawn != 0
- move  out  1  single-cycle move-down pulse to all slots
- game_over  out  1  high in S_OVER
- score  out  16  saturating kill count

Behaviour:
- Reset: reset, synchronous, active-high; clock clk. On reset:
  - state S_IDLE; spawn=0, move=0, write_x_d=0, game_over=0, score=0.
  - Spawn and move counters 0; pending=0; rr_ptr=0; LFSR=10'h1A5.
- States:
  - S_IDLE: to S_RUN when start=1. Counters held at 0.
  - S_RUN: counters run. To S_OVER on the first cycle any slot i has alive[i]=1 and enemy_y[i] >= LOSE_Y (unsigned compare).
  - S_OVER: spawn and move forced 0; score frozen; game_over=1. Exit only via reset.
- LFSR: 10-bit Fibonacci, taps 10,7 (x^10+x^7+1). Steps every cycle in every state except reset; never all-zero.
- Spawn counter:
  - Counts 0..SPAWN_TICKS-1 in S_RUN. At terminal count it wraps to 0 and sets pending.
  - pending is one bit: a second expiry while already pending is dropped, not stacked.
- Spawn issue, evaluated each S_RUN cycle while pending=1:
  - Free slot = alive[i]=0; dying enemies count as free.
  - Candidate = first free slot searching from rr_ptr upward, wrapping modulo N_ENEMIES.
  - Condition to issue: a free slot exists AND X_MIN <= LFSR <= X_MAX. Otherwise retry next cycle (rejection sampling).
  - On issue (registered, visible the next cycle):
    - spawn = one-hot(candidate) for exactly 1 cycle; write_x_d = that LFSR value.
    - pending cleared; rr_ptr = candidate+1 mod N_ENEMIES.
  - write_x_d holds its last value when spawn=0.
- Move counter: counts 0..MOVE_TICKS-1 in S_RUN; at terminal count, move=1 for the next cycle only.
- Score: each cycle in S_RUN, score += popcount(killed), saturating at 16'hFFFF. Kills arriving in the same cycle as the game-over transition are still counted.
- Simultaneous events:
  - spawn and move may assert in the same cycle.
  - A slot spawned in the same cycle as a move is unaffected, because enemy slots only move when already alive.
- Arithmetic: counter widths are $clog2 of their tick parameter; popcount width is $clog2(N_ENEMIES+1), zero-extended to 16 bits.

Optional Feature:
- Macro ENEMY_SPEEDUP_EN.
- Defined:
  - level (2 bits, reset 0) increments every 16 scored kills, saturating at 3.
  - Move terminal count becomes (MOVE_TICKS>>level)-1.
  - A level change takes effect at the next counter wrap.
  - Output port level[1:0] is added.
- Undefined: fixed MOVE_TICKS period; no level port or logic.

Decomposition:
- Add to enemy_def package:
  - sched_state_t enum {S_IDLE, S_RUN, S_OVER}.
  - Constants LFSR_SEED=10'h1A5, SCORE_W=16.
  - Function popcount.
- Move and spawn timers reuse upctr.
- One natural sub-module: rr_free_pick (combinational round-robin first-free finder: inputs alive and ptr, outputs found and one-hot/index).

Test Plan (SPAWN_TICKS=10, MOVE_TICKS=7, N=4, X_MIN=32, X_MAX=607):
- Reset, then start=1 with all slots dead -> first spawn=4'b0001 with 32<=write_x_d<=607, between 11 and ~20 cycles after start; rr_ptr=1; next spawn 4'b0010.
- All alive=4'b1111 across two spawn expiries, then drop alive[2] -> exactly one spawn=4'b0100, no second pulse (pending not stacked).
- Run 70 cycles in S_RUN -> move pulses every 7 cycles, each exactly 1 cycle wide, first on cycle 8 after entering S_RUN.
- killed=4'b1011 for 1 cycle -> score increments by 3; preload score to 16'hFFFE, then killed=4'b0011 -> score=16'hFFFF.
- alive[3]=1 with enemy_y[3]=440 -> game_over=1 the next cycle; spawn/move stay 0 thereafter; enemy_y=439 does not trigger; alive=0 with y=450 does not trigger.
- Assert reset mid-run with pending=1 -> all outputs return to reset values next cycle; no spawn after reset until start.

Source files
------------

// File: rtl/enemy_def_pkg.sv
// enemy_def: shared types, constants and helpers for the enemy scheduler
package enemy_def;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_OVER} sched_state_t;
  localparam logic [9:0] LFSR_SEED = 10'h1A5;
  localparam int SCORE_W = 16;
  function automatic logic [4:0] popcount(input logic [15:0] v);
    popcount = '0;
    for (int i = 0; i < 16; i++) popcount = popcount + 5'(v[i]);
  endfunction
endpackage

// File: rtl/enemy_scheduler_rr_free_pick.sv
// rr_free_pick: combinational round-robin first-free slot finder
//   alive  : per-slot alive flags (a clear bit is a free slot)
//   ptr    : slot index where the search starts
//   found  : some slot is free
//   idx    : first free slot at or after ptr, wrapping
//   onehot : one-hot of idx, zero when nothing is free
module rr_free_pick #(
  parameter int N  = 8,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  alive,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] idx,
  output logic [N-1:0]  onehot
);
  logic [IW:0] j;
  always_comb begin
    found = 1'b0;
    idx = '0;
    j = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = {1'b0, ptr} + (IW+1)'(k);
      j = j >= (IW+1)'(N) ? j - (IW+1)'(N) : j;
      found = found | !alive[j[IW-1:0]];
      idx = !alive[j[IW-1:0]] ? j[IW-1:0] : idx;
    end
    onehot = found ? N'(1) << idx : '0;
  end
endmodule

// File: rtl/upctr.sv
// upctr: wrapping up-counter 0..term, held at 0 by clr; wrap flags the terminal-count cycle
//   clk, reset : clock, synchronous active-high reset
//   clr        : hold count at 0
//   en         : advance count
//   term       : terminal count (inclusive)
//   wrap       : high in the cycle the count equals term while enabled
module upctr #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic         wrap
);
  logic [W-1:0] cnt;
  assign wrap = en && cnt == term;
  always_ff @(posedge clk) begin
    if (reset || clr) cnt <= '0;
    else if (en) cnt <= wrap ? '0 : cnt + 1'b1;
  end
endmodule

// File: rtl/enemy_scheduler.sv
// enemy_scheduler: spawn timing/placement, move pulses, kill scoring and game-over detection
//   clk, reset : clock, synchronous active-high reset
//   start      : leaves S_IDLE
//   alive      : per-slot alive flags; killed: per-slot one-cycle kill flags
//   enemy_y    : per-slot centre y, slot i at [9i+8:9i]
//   spawn      : one-hot one-cycle spawn command; write_x_d: spawn x (held between spawns)
//   move       : one-cycle move-down pulse; game_over: high in S_OVER
//   score      : saturating kill count
//   level      : speed level, only with ENEMY_SPEEDUP_EN defined
module enemy_scheduler
  import enemy_def::*;
#(
  parameter int         N_ENEMIES   = 8,
  parameter int         SPAWN_TICKS = 50_000_000,
  parameter int         MOVE_TICKS  = 25_000_000,
  parameter logic [8:0] LOSE_Y      = 9'd440,
  parameter logic [9:0] X_MIN       = 10'd32,
  parameter logic [9:0] X_MAX       = 10'd607
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [N_ENEMIES-1:0]     alive,
  input  logic [N_ENEMIES-1:0]     killed,
  input  logic [9*N_ENEMIES-1:0]   enemy_y,
  output logic [N_ENEMIES-1:0]     spawn,
  output logic [9:0]               write_x_d,
  output logic                     move,
  output logic                     game_over,
`ifdef ENEMY_SPEEDUP_EN
  output logic [1:0]               level,
`endif
  output logic [SCORE_W-1:0]       score
);
  localparam int IW = $clog2(N_ENEMIES);
  localparam int SW = $clog2(SPAWN_TICKS);
  localparam int MW = $clog2(MOVE_TICKS);
  localparam int PW = $clog2(N_ENEMIES + 1);
  sched_state_t state, state_n;
  logic [9:0] lfsr;
  logic pending, lose, run, issue, spawn_wrap, move_wrap, found;
  logic [IW-1:0] rr_ptr, idx;
  logic [N_ENEMIES-1:0] pick;
  logic [MW-1:0] move_term;
  logic [PW-1:0] kills;
  logic [SCORE_W:0] score_sum;
  assign run = state == S_RUN;
  assign game_over = state == S_OVER;
  assign kills = PW'(popcount(16'(killed)));
  assign score_sum = {1'b0, score} + (SCORE_W+1)'(kills);
  assign issue = run && pending && found && lfsr >= X_MIN && lfsr <= X_MAX;
  always_comb begin
    lose = 1'b0;
    for (int i = 0; i < N_ENEMIES; i++) lose = lose | (alive[i] && enemy_y[9*i +: 9] >= LOSE_Y);
    state_n = (state == S_IDLE && start) ? S_RUN : (run && lose) ? S_OVER : state;
  end
  rr_free_pick #(.N(N_ENEMIES), .IW(IW)) u_pick (
    .alive(alive), .ptr(rr_ptr), .found(found), .idx(idx), .onehot(pick)
  );
  upctr #(.W(SW)) u_spawn_ctr (
    .clk(clk), .reset(reset), .clr(!run), .en(run), .term(SW'(SPAWN_TICKS - 1)), .wrap(spawn_wrap)
  );
  upctr #(.W(MW)) u_move_ctr (
    .clk(clk), .reset(reset), .clr(!run), .en(run), .term(move_term), .wrap(move_wrap)
  );
`ifdef ENEMY_SPEEDUP_EN
  // lvl_eff only follows level at a wrap so the running count never skips past a shrunk terminal
  logic [1:0] lvl_eff;
  logic [3:0] kill_acc;
  logic [4:0] kill_sum;
  assign kill_sum = {1'b0, kill_acc} + 5'(kills);
  assign move_term = MW'((MOVE_TICKS >> lvl_eff) - 1);
  always_ff @(posedge clk) begin
    if (reset) begin
      lvl_eff <= '0;
      kill_acc <= '0;
      level <= '0;
    end else begin
      if (move_wrap) lvl_eff <= level;
      if (run) kill_acc <= kill_sum[3:0];
      if (run && kill_sum[4] && level != 2'd3) level <= level + 1'b1;
    end
  end
`else
  assign move_term = MW'(MOVE_TICKS - 1);
`endif
  always_ff @(posedge clk) begin
    state <= reset ? S_IDLE : state_n;
  end
  // spawn/move are suppressed in the losing cycle so nothing leaks into S_OVER
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr <= LFSR_SEED;
      pending <= 1'b0;
      rr_ptr <= '0;
      spawn <= '0;
      write_x_d <= '0;
      move <= 1'b0;
      score <= '0;
    end else begin
      lfsr <= {lfsr[8:0], lfsr[9] ^ lfsr[6]};
      pending <= run && (spawn_wrap || (pending && !issue));
      spawn <= (issue && !lose) ? pick : '0;
      move <= move_wrap && !lose;
      if (issue) write_x_d <= lfsr;
      if (issue) rr_ptr <= idx == IW'(N_ENEMIES - 1) ? '0 : idx + 1'b1;
      if (run) score <= score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
    end
  end
endmodule

// File: tb/tb_enemy_scheduler.sv
// tb_enemy_scheduler: directed self-checking bench for enemy_scheduler (N=4, spawn 10, move 7)
module tb_enemy_scheduler;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [3:0] alive = '0, killed = '0;
  logic [35:0] enemy_y = '0;
  logic [3:0] spawn;
  logic [9:0] write_x_d;
  logic move, game_over;
  logic [15:0] score;
  int checks = 0, fails = 0, run_c = 0;
  always #5 clk = ~clk;
  enemy_scheduler #(
    .N_ENEMIES(4), .SPAWN_TICKS(10), .MOVE_TICKS(7),
    .LOSE_Y(9'd440), .X_MIN(10'd32), .X_MAX(10'd607)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .alive(alive), .killed(killed),
    .enemy_y(enemy_y), .spawn(spawn), .write_x_d(write_x_d), .move(move),
    .game_over(game_over), .score(score)
  );
  // reference model of spawn timing, slot choice and spawn x
  logic [9:0] m_lfsr, m_x;
  logic [1:0] m_st, m_rr, m_cand;
  logic [3:0] m_cnt, m_sp;
  logic m_pend, m_lose, m_found, m_issue;
  always @(posedge clk) begin
    if (reset) begin
      m_lfsr <= 10'h1A5; m_x <= '0; m_st <= 2'd0; m_rr <= '0;
      m_cnt <= '0; m_sp <= '0; m_pend <= 1'b0;
    end else begin
      m_lose = 1'b0;
      for (int i = 0; i < 4; i++) if (alive[i] && enemy_y[9*i +: 9] >= 9'd440) m_lose = 1'b1;
      m_found = 1'b0;
      m_cand = '0;
      for (int k = 3; k >= 0; k--) if (!alive[2'(int'(m_rr) + k)]) begin m_found = 1'b1; m_cand = 2'(int'(m_rr) + k); end
      m_issue = m_st == 2'd1 && m_pend && m_found && m_lfsr >= 10'd32 && m_lfsr <= 10'd607;
      m_sp <= (m_issue && !m_lose) ? 4'b0001 << m_cand : 4'b0000;
      if (m_issue) begin m_x <= m_lfsr; m_rr <= m_cand + 2'd1; end
      if (m_st == 2'd1) begin
        m_cnt <= m_cnt == 4'd9 ? 4'd0 : m_cnt + 4'd1;
        m_pend <= m_cnt == 4'd9 || (m_pend && !m_issue);
      end
      m_lfsr <= {m_lfsr[8:0], m_lfsr[9] ^ m_lfsr[6]};
      m_st <= (m_st == 2'd0 && start) ? 2'd1 : (m_st == 2'd1 && m_lose) ? 2'd2 : m_st;
    end
  end
  task automatic step();
    @(negedge clk);
    run_c++;
  endtask
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    checks++; if (spawn !== 4'b0) begin fails++; $display("FAIL reset_spawn got=%b exp=0000", spawn); end
    checks++; if (move !== 1'b0) begin fails++; $display("FAIL reset_move got=%b exp=0", move); end
    checks++; if (write_x_d !== 10'd0) begin fails++; $display("FAIL reset_x got=%0d exp=0", write_x_d); end
    checks++; if (game_over !== 1'b0) begin fails++; $display("FAIL reset_game_over got=%b exp=0", game_over); end
    checks++; if (score !== 16'd0) begin fails++; $display("FAIL reset_score got=%0d exp=0", score); end
    repeat (15) begin
      step();
      checks++; if (spawn !== 4'b0 || move !== 1'b0) begin fails++; $display("FAIL idle_quiet spawn=%b move=%b exp=0000/0", spawn, move); end
    end
  endtask
  task automatic test_spawn();
    int nsp;
    logic [3:0] exp;
    nsp = 0;
    alive = 4'b0000;
    start = 1'b1;
    run_c = 0;
    step();
    start = 1'b0;
    while (nsp < 2 && run_c < 60) begin
      checks++; if (spawn !== m_sp || write_x_d !== m_x) begin fails++; $display("FAIL spawn_model c=%0d got=%b/%0d exp=%b/%0d", run_c, spawn, write_x_d, m_sp, m_x); end
      if (spawn != 4'b0) begin
        nsp++;
        exp = nsp == 1 ? 4'b0001 : 4'b0010;
        checks++; if (spawn !== exp) begin fails++; $display("FAIL spawn_slot got=%b exp=%b", spawn, exp); end
        checks++; if (write_x_d < 10'd32 || write_x_d > 10'd607) begin fails++; $display("FAIL spawn_x_range got=%0d exp=32..607", write_x_d); end
        if (nsp == 1) begin
          checks++; if (run_c < 12) begin fails++; $display("FAIL spawn_early got=cycle %0d exp>=12", run_c); end
        end
      end
      if (nsp < 2) step();
    end
    checks++; if (nsp != 2) begin fails++; $display("FAIL spawn_timeout got=%0d spawns exp=2", nsp); end
    alive = 4'b1111;
  endtask
  task automatic test_no_stack();
    int n;
    n = 0;
    repeat (25) begin
      step();
      checks++; if (spawn !== 4'b0) begin fails++; $display("FAIL full_no_spawn got=%b exp=0000", spawn); end
    end
    alive = 4'b1011;
    for (int t = 0; t < 25 && n == 0; t++) begin
      step();
      checks++; if (spawn !== m_sp || write_x_d !== m_x) begin fails++; $display("FAIL stack_model got=%b/%0d exp=%b/%0d", spawn, write_x_d, m_sp, m_x); end
      if (spawn != 4'b0) begin
        n++;
        alive = 4'b1111;
        checks++; if (spawn !== 4'b0100) begin fails++; $display("FAIL stack_slot got=%b exp=0100", spawn); end
      end
    end
    alive = 4'b1111;
    checks++; if (n != 1) begin fails++; $display("FAIL stack_timeout got=%0d spawns exp=1", n); end
    repeat (15) begin
      step();
      checks++; if (spawn !== 4'b0) begin fails++; $display("FAIL stack_second got=%b exp=0000", spawn); end
    end
  endtask
  task automatic test_move();
    logic exp;
    repeat (70) begin
      step();
      exp = run_c >= 8 && (run_c - 8) % 7 == 0;
      checks++; if (move !== exp) begin fails++; $display("FAIL move c=%0d got=%b exp=%b", run_c, move, exp); end
    end
  endtask
  task automatic test_score();
    checks++; if (score !== 16'd0) begin fails++; $display("FAIL score_init got=%0d exp=0", score); end
    killed = 4'b1011;
    step();
    killed = 4'b0000;
    checks++; if (score !== 16'd3) begin fails++; $display("FAIL score_1011 got=%0d exp=3", score); end
    step();
    checks++; if (score !== 16'd3) begin fails++; $display("FAIL score_hold got=%0d exp=3", score); end
    killed = 4'b1111;
    repeat (16382) step();
    killed = 4'b0111;
    step();
    killed = 4'b0000;
    checks++; if (score !== 16'hFFFE) begin fails++; $display("FAIL score_fffe got=%h exp=fffe", score); end
    killed = 4'b0011;
    step();
    killed = 4'b0000;
    checks++; if (score !== 16'hFFFF) begin fails++; $display("FAIL score_sat got=%h exp=ffff", score); end
    killed = 4'b0001;
    step();
    killed = 4'b0000;
    checks++; if (score !== 16'hFFFF) begin fails++; $display("FAIL score_sat_hold got=%h exp=ffff", score); end
  endtask
  task automatic test_game_over();
    alive = 4'b1000;
    enemy_y[35:27] = 9'd439;
    repeat (3) begin
      step();
      checks++; if (game_over !== 1'b0) begin fails++; $display("FAIL over_439 got=%b exp=0", game_over); end
    end
    alive = 4'b0000;
    enemy_y[35:27] = 9'd450;
    repeat (3) begin
      step();
      checks++; if (game_over !== 1'b0) begin fails++; $display("FAIL over_dead got=%b exp=0", game_over); end
    end
    alive = 4'b1000;
    enemy_y[35:27] = 9'd440;
    step();
    checks++; if (game_over !== 1'b1) begin fails++; $display("FAIL over_440 got=%b exp=1", game_over); end
    alive = 4'b0000;
    killed = 4'b1111;
    repeat (20) begin
      step();
      checks++; if (spawn !== 4'b0 || move !== 1'b0 || game_over !== 1'b1) begin fails++; $display("FAIL over_quiet spawn=%b move=%b go=%b exp=0000/0/1", spawn, move, game_over); end
    end
    killed = 4'b0000;
  endtask
  task automatic test_reset_mid_run();
    reset = 1'b1;
    step();
    reset = 1'b0;
    alive = 4'b1111;
    enemy_y = '0;
    start = 1'b1;
    run_c = 0;
    step();
    start = 1'b0;
    repeat (10) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    alive = 4'b0000;
    checks++; if (spawn !== 4'b0) begin fails++; $display("FAIL mid_reset_spawn got=%b exp=0000", spawn); end
    checks++; if (move !== 1'b0) begin fails++; $display("FAIL mid_reset_move got=%b exp=0", move); end
    checks++; if (write_x_d !== 10'd0) begin fails++; $display("FAIL mid_reset_x got=%0d exp=0", write_x_d); end
    checks++; if (game_over !== 1'b0) begin fails++; $display("FAIL mid_reset_go got=%b exp=0", game_over); end
    checks++; if (score !== 16'd0) begin fails++; $display("FAIL mid_reset_score got=%0d exp=0", score); end
    repeat (30) begin
      step();
      checks++; if (spawn !== 4'b0 || move !== 1'b0 || game_over !== 1'b0) begin fails++; $display("FAIL mid_reset_idle spawn=%b move=%b go=%b exp=0000/0/0", spawn, move, game_over); end
    end
  endtask
  task automatic test_transition_kill();
    start = 1'b1;
    run_c = 0;
    step();
    start = 1'b0;
    repeat (3) step();
    killed = 4'b0011;
    alive = 4'b1000;
    enemy_y[35:27] = 9'd440;
    step();
    killed = 4'b1111;
    checks++; if (game_over !== 1'b1) begin fails++; $display("FAIL trans_go got=%b exp=1", game_over); end
    checks++; if (score !== 16'd2) begin fails++; $display("FAIL trans_score got=%0d exp=2", score); end
    repeat (3) begin
      step();
      checks++; if (score !== 16'd2 || spawn !== 4'b0) begin fails++; $display("FAIL trans_frozen score=%0d spawn=%b exp=2/0000", score, spawn); end
    end
    killed = 4'b0000;
  endtask
  initial begin
    test_reset();
    test_spawn();
    test_no_stack();
    test_move();
    test_score();
    test_game_over();
    test_reset_mid_run();
    test_transition_kill();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
